// File: rtl/pll_ctrl_pkg.sv
// Shared types and default constants for the PLL reset/lock sequencer.
package pll_ctrl_pkg;

  // Sequencer phases, exported on the debug state output of the interface.
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Default timing for a 50 MHz reference clock.
  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
  localparam int DEF_LOCK_STABLE_CYC  = 256;
  localparam int DEF_MAX_RETRIES      = 3;
  localparam int DEF_SYNC_STAGES      = 2;

endpackage

// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the sequencer and its surroundings (PLL wrapper,
// restart source, downstream reset consumers).
interface pll_reset_seq_if
  import pll_ctrl_pkg::*;
#(
  parameter int RETRY_W = 2   // must equal $clog2(MAX_RETRIES+1) of the sequencer
);

  // Signalling contract: there is no valid/ready handshake on this bundle.
  // Every signal is a level. pll_locked_i is asynchronous to refclk and is
  // only ever consumed through the synchronizer; restart_i is synchronous to
  // refclk and acts on every edge where it is high. All sequencer outputs are
  // registered on refclk and change together with the state register.
  logic               pll_locked_i;
  logic               restart_i;
  logic               pll_rst_o;
  logic               sys_rst_n_o;
  logic               ready_o;
  logic               fault_o;
  logic               lock_loss_o;
  logic [RETRY_W-1:0] retry_cnt_o;
  state_t             state;        // debug view of the sequencer FSM

  // Sequencer side.
  modport master (
    input  pll_locked_i,
    input  restart_i,
    output pll_rst_o,
    output sys_rst_n_o,
    output ready_o,
    output fault_o,
    output lock_loss_o,
    output retry_cnt_o,
    output state
  );

  // PLL / system side.
  modport slave (
    output pll_locked_i,
    output restart_i,
    input  pll_rst_o,
    input  sys_rst_n_o,
    input  ready_o,
    input  fault_o,
    input  lock_loss_o,
    input  retry_cnt_o,
    input  state
  );

endinterface

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the PLL lock indication into refclk.
module pll_lock_sync #(
  parameter int STAGES = 2   // at least 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; clears to unlocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset and lock sequencer: pulses the PLL reset, waits for lock with a
// timeout and bounded retries, qualifies lock as stable, then releases the
// downstream reset. Loss of lock in RUN restarts the whole sequence.
module pll_reset_seq
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES,   // at least 1
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES
) (
  input  logic            refclk,
  input  logic            rst_n,
  pll_reset_seq_if.master bus
);

  // One counter serves all timed phases, so it is sized for the longest one.
  localparam int MAX_A   = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYC) ? MAX_A : LOCK_STABLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  // A phase of N cycles ends on the edge where the counter holds N-1.
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_next;
  logic               locked_s;

  logic               pll_rst_d;
  logic               run_d;
  logic               fault_d;
  logic               lock_loss_d;

  logic               pll_rst_q;
  logic               sys_rst_n_q;
  logic               ready_q;
  logic               fault_q;
  logic               lock_loss_q;

  pll_lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked_i),
    .q     (locked_s)
  );

  // State register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_PLL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and retry bookkeeping; restart overrides everything, and in
  // WAIT_LOCK a lock seen in the timeout cycle wins over the timeout.
  always_comb begin
    next_state = state;
    retry_next = retry_cnt;
    if (bus.restart_i) begin
      next_state = RESET_PLL;
      retry_next = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            next_state = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            next_state = STABILIZE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              next_state = FAULT;
            end else begin
              next_state = RESET_PLL;
              retry_next = retry_cnt + RETRY_W'(1);
            end
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            next_state = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            next_state = RUN;
            retry_next = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            next_state = RESET_PLL;
            retry_next = '0;
          end
        end
        FAULT: begin
          next_state = FAULT;
        end
        default: begin
          next_state = RESET_PLL;
          retry_next = '0;
        end
      endcase
    end
  end

  // Shared phase counter: restarts on every phase entry (a restart request
  // counts as re-entering RESET_PLL) and only runs in the timed phases.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      retry_cnt <= '0;
    end else begin
      retry_cnt <= retry_next;
      if (bus.restart_i || (next_state != state)) begin
        cnt <= '0;
      end else if (state inside {RESET_PLL, WAIT_LOCK, STABILIZE}) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Output decode from the next state so outputs move with the state register.
  always_comb begin
    pll_rst_d   = (next_state == RESET_PLL) || (next_state == FAULT);
    run_d       = (next_state == RUN);
    fault_d     = (next_state == FAULT);
    lock_loss_d = (state == RUN) && (next_state == RESET_PLL) && !bus.restart_i;
  end

  // Output registers; reset values hold the PLL in reset and the system down.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_loss_q <= 1'b0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= run_d;
      ready_q     <= run_d;
      fault_q     <= fault_d;
      lock_loss_q <= lock_loss_d;
    end
  end

  assign bus.pll_rst_o   = pll_rst_q;
  assign bus.sys_rst_n_o = sys_rst_n_q;
  assign bus.ready_o     = ready_q;
  assign bus.fault_o     = fault_q;
  assign bus.lock_loss_o = lock_loss_q;
  assign bus.retry_cnt_o = retry_cnt;
  assign bus.state       = state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_pll_reset_seq;
  import pll_ctrl_pkg::*;

  localparam int T_PULSE   = 4;
  localparam int T_TIMEOUT = 20;
  localparam int T_STABLE  = 8;
  localparam int T_MAX     = 2;
  localparam int T_SYNC    = 2;
  localparam int RW        = $clog2(T_MAX + 1);
  localparam int W         = 5 + RW;

  // Observation vector: {pll_rst, sys_rst_n, ready, fault, lock_loss, retry}
  localparam logic [W-1:0] O_RESET = 7'b1000000;
  localparam logic [W-1:0] O_PULSE = 7'b1000000;
  localparam logic [W-1:0] O_IDLE  = 7'b0000000;
  localparam logic [W-1:0] O_RUN   = 7'b0110000;
  localparam logic [W-1:0] O_LOSS  = 7'b1000100;

  typedef struct {
    int           len;
    bit           locked;
    bit           restart;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  logic refclk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  logic [W-1:0] exp_q[$];

  pll_reset_seq_if #(.RETRY_W(RW)) bus ();

  pll_reset_seq #(
    .RST_PULSE_CYC    (T_PULSE),
    .LOCK_TIMEOUT_CYC (T_TIMEOUT),
    .LOCK_STABLE_CYC  (T_STABLE),
    .MAX_RETRIES      (T_MAX),
    .SYNC_STAGES      (T_SYNC)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  task automatic tick();
    @(negedge refclk);
  endtask

  function automatic logic [W-1:0] obs();
    return {bus.pll_rst_o, bus.sys_rst_n_o, bus.ready_o, bus.fault_o,
            bus.lock_loss_o, bus.retry_cnt_o};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pll_locked_i = 1'b0;
    bus.restart_i = 1'b0;
    repeat (2) tick();
    check("reset_state", obs(), O_RESET);
    rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic run_expect(input int len, input bit lk, input bit rs,
                            input logic [W-1:0] exp, input string name);
    for (int i = 0; i < len; i++) begin
      bus.pll_locked_i = lk;
      bus.restart_i = rs;
      tick();
      check(name, obs(), exp);
    end
  endtask

  // Assert rst_n between edges and look at the outputs before any edge.
  task automatic async_reset_check(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, obs(), O_RESET);
    tick();
  endtask

  // ---------------- reference model ----------------
  localparam int P_PULSE = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  bit sync_q[$];
  int m_phase;
  int m_elapsed;
  int m_retries;
  bit m_loss;

  function automatic void go(input int p);
    m_phase = p;
    m_elapsed = 0;
  endfunction

  function automatic void model_reset();
    sync_q = {};
    for (int i = 0; i < T_SYNC; i++) sync_q.push_back(1'b0);
    m_phase = P_PULSE;
    m_elapsed = 0;
    m_retries = 0;
    m_loss = 1'b0;
  endfunction

  // One refclk edge: the sequencer sees the lock input from SYNC edges ago,
  // and every phase lasts its nominal number of cycles since entry.
  function automatic void model_edge(input bit lk, input bit rs);
    bit ls;
    logic [RW-1:0] r;
    ls = sync_q.pop_front();
    sync_q.push_back(lk);
    m_loss = 1'b0;
    m_elapsed++;
    if (rs) begin
      m_retries = 0;
      go(P_PULSE);
    end else begin
      case (m_phase)
        P_PULSE: if (m_elapsed >= T_PULSE) go(P_WAIT);
        P_WAIT: begin
          if (ls) go(P_STAB);
          else if (m_elapsed >= T_TIMEOUT) begin
            if (m_retries >= T_MAX) go(P_FAULT);
            else begin
              m_retries++;
              go(P_PULSE);
            end
          end
        end
        P_STAB: begin
          if (!ls) go(P_WAIT);
          else if (m_elapsed >= T_STABLE) begin
            m_retries = 0;
            go(P_RUN);
          end
        end
        P_RUN: begin
          if (!ls) begin
            m_loss = 1'b1;
            m_retries = 0;
            go(P_PULSE);
          end
        end
        default: ;
      endcase
    end
    r = RW'(m_retries);
    exp_q.push_back({(m_phase == P_PULSE) || (m_phase == P_FAULT),
                     m_phase == P_RUN, m_phase == P_RUN, m_phase == P_FAULT,
                     m_loss, r});
  endfunction

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    int pulses;
    int width;
    int fault_at;
    int ready_seen;
    int rise_at[$];
    int widths[$];
    bit prev;
    int seg_left;
    bit cur_lk;
    bit rs;

    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.pll_locked_i = 1'b0;
    bus.restart_i = 1'b0;

    // Normal bring-up, lock loss in RUN and re-lock; edge numbers after release.
    vecs.push_back('{3,  1'b0, 1'b0, O_PULSE, "first_pulse"});     // edges 1-3
    vecs.push_back('{6,  1'b0, 1'b0, O_IDLE,  "wait_lock"});       // edges 4-9
    vecs.push_back('{10, 1'b1, 1'b0, O_IDLE,  "sync_stabilize"});  // edges 10-19
    vecs.push_back('{5,  1'b1, 1'b0, O_RUN,   "ready_at_20"});     // edges 20-24
    vecs.push_back('{2,  1'b0, 1'b0, O_RUN,   "loss_in_sync"});    // edges 25-26
    vecs.push_back('{1,  1'b0, 1'b0, O_LOSS,  "lock_loss_pulse"}); // edge 27
    vecs.push_back('{3,  1'b0, 1'b0, O_PULSE, "loss_rst_pulse"});  // edges 28-30
    vecs.push_back('{10, 1'b1, 1'b0, O_IDLE,  "relock"});          // edges 31-40
    vecs.push_back('{3,  1'b1, 1'b0, O_RUN,   "relock_run"});      // edges 41-43

    do_reset();
    foreach (vecs[i]) run_expect(vecs[i].len, vecs[i].locked, vecs[i].restart,
                                 vecs[i].exp, vecs[i].name);

    // Lock glitch in STABILIZE: 5 high, 3 low, then high from edge 18.
    do_reset();
    run_expect(3, 1'b0, 1'b0, O_PULSE, "glitch_pulse");
    run_expect(6, 1'b0, 1'b0, O_IDLE,  "glitch_wait");
    run_expect(5, 1'b1, 1'b0, O_IDLE,  "glitch_high");
    run_expect(3, 1'b0, 1'b0, O_IDLE,  "glitch_low");
    run_expect(10, 1'b1, 1'b0, O_IDLE, "glitch_restab");
    run_expect(1, 1'b1, 1'b0, O_RUN,   "glitch_ready");

    // Synchronized lock arriving on the timeout edge (edge 24): lock wins.
    do_reset();
    run_expect(3, 1'b0, 1'b0, O_PULSE, "race_pulse");
    run_expect(18, 1'b0, 1'b0, O_IDLE, "race_wait");
    run_expect(10, 1'b1, 1'b0, O_IDLE, "race_lock_wins");
    run_expect(1, 1'b1, 1'b0, O_RUN,   "race_ready");

    // No lock at all: three reset pulses then FAULT.
    do_reset();
    pulses = 0;
    width = 1;
    fault_at = -1;
    ready_seen = 0;
    prev = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      bus.pll_locked_i = 1'b0;
      bus.restart_i = 1'b0;
      tick();
      if (bus.pll_rst_o && !prev) begin
        width = 1;
        rise_at.push_back(c);
      end else if (bus.pll_rst_o) begin
        width++;
      end else if (prev) begin
        pulses++;
        widths.push_back(width);
      end
      if (bus.fault_o && fault_at < 0) fault_at = c;
      if (bus.ready_o || bus.sys_rst_n_o) ready_seen++;
      if (c == 30) check_int("nolock_retry_after_1st", int'(bus.retry_cnt_o), 1);
      prev = bus.pll_rst_o;
    end
    check_int("nolock_pulses", pulses, 3);
    for (int i = 0; i < 3; i++)
      check_int("nolock_pulse_width", (i < widths.size()) ? widths[i] : -1, T_PULSE);
    check_int("nolock_rise2", (rise_at.size() > 0) ? rise_at[0] : -1, 24);
    check_int("nolock_rise3", (rise_at.size() > 1) ? rise_at[1] : -1, 48);
    check_int("nolock_fault_edge", fault_at, 72);
    check_int("nolock_ready_seen", ready_seen, 0);
    check("nolock_fault_state", obs(), 7'b1001010);

    // Restart from FAULT, then a normal bring-up.
    run_expect(1, 1'b0, 1'b1, O_PULSE, "restart_exit_fault");
    run_expect(3, 1'b0, 1'b0, O_PULSE, "restart_pulse");
    run_expect(1, 1'b0, 1'b0, O_IDLE,  "restart_pulse_end");
    run_expect(10, 1'b1, 1'b0, O_IDLE, "restart_bringup");
    run_expect(1, 1'b1, 1'b0, O_RUN,   "restart_ready");

    // Restart held high in RUN keeps the PLL in reset; pulse runs after release.
    run_expect(6, 1'b1, 1'b1, O_PULSE, "restart_held");
    run_expect(3, 1'b1, 1'b0, O_PULSE, "restart_release");
    run_expect(1, 1'b1, 1'b0, O_IDLE,  "restart_release_end");

    // Asynchronous reset mid-STABILIZE and in RUN.
    do_reset();
    run_expect(3, 1'b0, 1'b0, O_PULSE, "arst_pulse");
    run_expect(6, 1'b0, 1'b0, O_IDLE,  "arst_wait");
    run_expect(4, 1'b1, 1'b0, O_IDLE,  "arst_stab");
    async_reset_check("async_reset_stabilize");
    do_reset();
    run_expect(3, 1'b0, 1'b0, O_PULSE, "arst2_pulse");
    run_expect(6, 1'b0, 1'b0, O_IDLE,  "arst2_wait");
    run_expect(10, 1'b1, 1'b0, O_IDLE, "arst2_stab");
    run_expect(3, 1'b1, 1'b0, O_RUN,   "arst2_run");
    async_reset_check("async_reset_run");

    // Randomized lock behaviour and restarts against the model.
    do_reset();
    model_reset();
    exp_q = {};
    seg_left = 0;
    cur_lk = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (seg_left == 0) begin
        seg_left = $urandom_range(1, 90);
        cur_lk = 1'($urandom_range(0, 1));
      end
      seg_left--;
      rs = ($urandom_range(0, 99) == 0);
      bus.pll_locked_i = cur_lk;
      bus.restart_i = rs;
      model_edge(cur_lk, rs);
      tick();
      if (exp_q.size() == 0) check_int("random_queue_empty", 0, 1);
      else check("random", obs(), exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
